// File: rtl/hq_y_match_if.sv
// Bus bundle for hq_y_match: Hq rows, channel norm, received samples and
// matched-filter results. The DUT takes the slave side.
interface hq_y_match_if;
    logic               start;
    logic [31:0]        in_rowHr0, in_rowHr1, in_rowHr2, in_rowHr3;
    logic [31:0]        in_rowHi0, in_rowHi1, in_rowHi2, in_rowHi3;
    logic               ready_Hq;
    logic [15:0]        D_h;
    logic               done_Dh;
    logic               y_valid;
    logic signed [15:0] y_re, y_im;
    logic               y_ready;
    logic signed [31:0] z_re0, z_re1, z_re2, z_re3;
    logic signed [31:0] z_im0, z_im1, z_im2, z_im3;
    logic [15:0]        Dh_out;
    logic               busy;
    logic               done;

    modport master (
        output start, in_rowHr0, in_rowHr1, in_rowHr2, in_rowHr3,
               in_rowHi0, in_rowHi1, in_rowHi2, in_rowHi3,
               ready_Hq, D_h, done_Dh, y_valid, y_re, y_im,
        input  y_ready, z_re0, z_re1, z_re2, z_re3,
               z_im0, z_im1, z_im2, z_im3, Dh_out, busy, done
    );

    modport slave (
        input  start, in_rowHr0, in_rowHr1, in_rowHr2, in_rowHr3,
               in_rowHi0, in_rowHi1, in_rowHi2, in_rowHi3,
               ready_Hq, D_h, done_Dh, y_valid, y_re, y_im,
        output y_ready, z_re0, z_re1, z_re2, z_re3,
               z_im0, z_im1, z_im2, z_im3, Dh_out, busy, done
    );
endinterface

// File: rtl/hq_y_match.sv
// Matched filter z = Hq^H * y over a 4x4 complex Hq and four streamed samples.
// Captures Hq and D_h in any order, then accumulates one row per accepted sample.
module hq_y_match (
    input  logic          clk,
    input  logic          rst,
    hq_y_match_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ACC, DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        hr_q [4];
    logic [31:0]        hi_q [4];
    logic [15:0]        dh_q;
    logic               h_got_q, d_got_q;
    logic [1:0]         cnt_q;
    logic signed [31:0] acc_re_q [4], acc_im_q [4];
    logic signed [31:0] acc_re_d [4], acc_im_d [4];
    logic signed [31:0] z_re_q [4], z_im_q [4];
    logic [31:0]        hr_row, hi_row;
    logic               accept, last;

    // Exact 8x16 signed product, sign-extended to accumulator width.
    function automatic logic signed [31:0] mul(input logic signed [7:0]  h,
                                               input logic signed [15:0] y);
        logic signed [23:0] p;
        p = 24'(h) * 24'(y);
        return 32'(p);
    endfunction

    assign accept = (state_q == ACC) && bus.y_valid;
    assign last   = accept && (cnt_q == 2'd3);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    if ((h_got_q || bus.ready_Hq) && (d_got_q || bus.done_Dh)) state_d = ACC;
            ACC:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hr_row = hr_q[cnt_q];
        hi_row = hi_q[cnt_q];
        for (int c = 0; c < 4; c++) begin
            acc_re_d[c] = acc_re_q[c] + mul(hr_row[8*c +: 8], bus.y_re)
                                      + mul(hi_row[8*c +: 8], bus.y_im);
            acc_im_d[c] = acc_im_q[c] + mul(hr_row[8*c +: 8], bus.y_im)
                                      - mul(hi_row[8*c +: 8], bus.y_re);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the row-word array is only eight words, so it is reset with everything else.
            for (int i = 0; i < 4; i++) begin
                hr_q[i]     <= '0;
                hi_q[i]     <= '0;
                acc_re_q[i] <= '0;
                acc_im_q[i] <= '0;
                z_re_q[i]   <= '0;
                z_im_q[i]   <= '0;
            end
            dh_q    <= '0;
            h_got_q <= 1'b0;
            d_got_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    for (int i = 0; i < 4; i++) begin
                        acc_re_q[i] <= '0;
                        acc_im_q[i] <= '0;
                        z_re_q[i]   <= '0;
                        z_im_q[i]   <= '0;
                    end
                    dh_q    <= '0;
                    h_got_q <= 1'b0;
                    d_got_q <= 1'b0;
                    cnt_q   <= '0;
                end
                LOAD: begin
                    // Each capture fires once; repeated strobes leave the first copy intact.
                    if (bus.ready_Hq && !h_got_q) begin
                        hr_q[0] <= bus.in_rowHr0;
                        hr_q[1] <= bus.in_rowHr1;
                        hr_q[2] <= bus.in_rowHr2;
                        hr_q[3] <= bus.in_rowHr3;
                        hi_q[0] <= bus.in_rowHi0;
                        hi_q[1] <= bus.in_rowHi1;
                        hi_q[2] <= bus.in_rowHi2;
                        hi_q[3] <= bus.in_rowHi3;
                        h_got_q <= 1'b1;
                    end
                    if (bus.done_Dh && !d_got_q) begin
                        dh_q    <= bus.D_h;
                        d_got_q <= 1'b1;
                    end
                end
                ACC: if (accept) begin
                    for (int i = 0; i < 4; i++) begin
                        acc_re_q[i] <= acc_re_d[i];
                        acc_im_q[i] <= acc_im_d[i];
                    end
                    cnt_q <= cnt_q + 2'd1;
                    if (last) begin
                        for (int i = 0; i < 4; i++) begin
                            z_re_q[i] <= acc_re_d[i];
                            z_im_q[i] <= acc_im_d[i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.z_re0   = z_re_q[0];
    assign bus.z_re1   = z_re_q[1];
    assign bus.z_re2   = z_re_q[2];
    assign bus.z_re3   = z_re_q[3];
    assign bus.z_im0   = z_im_q[0];
    assign bus.z_im1   = z_im_q[1];
    assign bus.z_im2   = z_im_q[2];
    assign bus.z_im3   = z_im_q[3];
    assign bus.Dh_out  = dh_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.y_ready = (state_q == ACC);
endmodule

// File: tb/tb_hq_y_match.sv
// Bench for hq_y_match: fixed vectors, capture-order and reset sequences, and
// random operations checked against a plain complex matrix-vector model.
module tb_hq_y_match;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hq_y_match_if bus ();
    hq_y_match dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int hr [4][4];
        int hi [4][4];
        int yre [4];
        int yim [4];
        int dh;
        int zre [4];
        int zim [4];
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t zero_vec();
        vec_t v;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v.hr[r][c] = 0;
                v.hi[r][c] = 0;
            end
            v.yre[r] = 0; v.yim[r] = 0; v.zre[r] = 0; v.zim[r] = 0;
        end
        v.dh = 0;
        return v;
    endfunction

    // z[c] = sum_r conj-weighted products: the complex matched filter written out directly.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        for (int c = 0; c < 4; c++) begin
            m.zre[c] = 0;
            m.zim[c] = 0;
            for (int r = 0; r < 4; r++) begin
                m.zre[c] += v.hr[r][c] * v.yre[r] + v.hi[r][c] * v.yim[r];
                m.zim[c] += v.hr[r][c] * v.yim[r] - v.hi[r][c] * v.yre[r];
            end
        end
        return m;
    endfunction

    function automatic int rnd_s8();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    function automatic int rnd_s16();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v = zero_vec();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v.hr[r][c] = rnd_s8();
                v.hi[r][c] = rnd_s8();
            end
            v.yre[r] = rnd_s16();
            v.yim[r] = rnd_s16();
        end
        v.dh = int'($urandom_range(65535, 0));
        return model(v);
    endfunction

    function automatic logic [31:0] pack(input vec_t v, input int r, input bit imag);
        logic [31:0] w;
        for (int c = 0; c < 4; c++)
            w[8*c +: 8] = imag ? 8'(v.hi[r][c]) : 8'(v.hr[r][c]);
        return w;
    endfunction

    function automatic logic [31:0] z_re(input int c);
        case (c)
            0: return bus.z_re0;
            1: return bus.z_re1;
            2: return bus.z_re2;
            default: return bus.z_re3;
        endcase
    endfunction

    function automatic logic [31:0] z_im(input int c);
        case (c)
            0: return bus.z_im0;
            1: return bus.z_im1;
            2: return bus.z_im2;
            default: return bus.z_im3;
        endcase
    endfunction

    task automatic drive_rows(input vec_t v);
        bus.in_rowHr0 = pack(v, 0, 1'b0); bus.in_rowHr1 = pack(v, 1, 1'b0);
        bus.in_rowHr2 = pack(v, 2, 1'b0); bus.in_rowHr3 = pack(v, 3, 1'b0);
        bus.in_rowHi0 = pack(v, 0, 1'b1); bus.in_rowHi1 = pack(v, 1, 1'b1);
        bus.in_rowHi2 = pack(v, 2, 1'b1); bus.in_rowHi3 = pack(v, 3, 1'b1);
    endtask

    task automatic scramble();
        bus.in_rowHr0 = $urandom; bus.in_rowHr1 = $urandom;
        bus.in_rowHr2 = $urandom; bus.in_rowHr3 = $urandom;
        bus.in_rowHi0 = $urandom; bus.in_rowHi1 = $urandom;
        bus.in_rowHi2 = $urandom; bus.in_rowHi3 = $urandom;
        bus.D_h = 16'($urandom);
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.ready_Hq = 1'b0; bus.done_Dh = 1'b0; bus.y_valid = 1'b0;
        bus.y_re = '0; bus.y_im = '0; bus.D_h = '0;
        bus.in_rowHr0 = '0; bus.in_rowHr1 = '0; bus.in_rowHr2 = '0; bus.in_rowHr3 = '0;
        bus.in_rowHi0 = '0; bus.in_rowHi1 = '0; bus.in_rowHi2 = '0; bus.in_rowHi3 = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(bus.busy),    32'd0);
        check({tag, "_done"},    32'(bus.done),    32'd0);
        check({tag, "_y_ready"}, 32'(bus.y_ready), 32'd0);
        check({tag, "_Dh_out"},  32'(bus.Dh_out),  32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_z_re%0d", tag, c), z_re(c), 32'd0);
            check($sformatf("%s_z_im%0d", tag, c), z_im(c), 32'd0);
        end
    endtask

    // mode 0: H and D_h captured together; 1: H first; 2: D_h first, the other after dly+1 cycles.
    task automatic start_op(input vec_t v, input int mode, input int dly, input string tag);
        drive_rows(v);
        bus.D_h   = 16'(v.dh);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_load"}, 32'(bus.busy), 32'd1);
        if (mode == 0) begin
            bus.ready_Hq = 1'b1; bus.done_Dh = 1'b1;
            tick();
        end else begin
            bus.ready_Hq = (mode == 1); bus.done_Dh = (mode != 1);
            tick();
            bus.ready_Hq = 1'b0; bus.done_Dh = 1'b0;
            for (int i = 0; i < dly; i++) begin
                scramble();
                bus.ready_Hq = (mode == 1); bus.done_Dh = (mode != 1);
                bus.y_valid = 1'b1; bus.y_re = 16'(rnd_s16()); bus.y_im = 16'(rnd_s16());
                tick();
                check({tag, "_y_ready_load"}, 32'(bus.y_ready), 32'd0);
            end
            bus.y_valid = 1'b0;
            scramble();
            if (mode == 1) begin
                bus.D_h = 16'(v.dh); bus.ready_Hq = 1'b0; bus.done_Dh = 1'b1;
            end else begin
                drive_rows(v); bus.ready_Hq = 1'b1; bus.done_Dh = 1'b0;
            end
            tick();
        end
        bus.ready_Hq = 1'b0; bus.done_Dh = 1'b0;
        scramble();
        check({tag, "_y_ready_acc"}, 32'(bus.y_ready), 32'd1);
    endtask

    task automatic feed(input vec_t v, input int max_gap, input bit hold_start, input string tag);
        if (hold_start) bus.start = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int gaps = int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gaps; g++) begin
                bus.y_valid = 1'b0; bus.y_re = 16'(rnd_s16()); bus.y_im = 16'(rnd_s16());
                tick();
                check({tag, "_gap_state"}, {30'd0, bus.y_ready, bus.done}, 32'd2);
            end
            bus.y_valid = 1'b1; bus.y_re = 16'(v.yre[r]); bus.y_im = 16'(v.yim[r]);
            tick();
            if (r < 3) check({tag, "_mid_state"}, {30'd0, bus.y_ready, bus.done}, 32'd2);
        end
        bus.y_valid = 1'b0;
        check({tag, "_done"},     32'(bus.done),    32'd1);
        check({tag, "_busy_done"}, 32'(bus.busy),   32'd1);
        check({tag, "_y_ready_done"}, 32'(bus.y_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_z_re%0d", tag, c), z_re(c), 32'(v.zre[c]));
            check($sformatf("%s_z_im%0d", tag, c), z_im(c), 32'(v.zim[c]));
        end
        check({tag, "_Dh_out"}, 32'(bus.Dh_out), 32'(v.dh & 16'hFFFF));
        tick();
        bus.start = 1'b0;
        check({tag, "_done_once"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"},      32'(bus.busy), 32'd0);
        tick();
        check({tag, "_idle_hold"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, "_z_hold"},    z_re(0), 32'(v.zre[0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [3];
        string names [3];
        vec_t  v, v2;

        clear_inputs();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check_all_zero("reset");

        // Fixed vectors with hand-derived results.
        names[0] = "identity"; names[1] = "conj"; names[2] = "extreme";
        tbl[0] = zero_vec();
        for (int r = 0; r < 4; r++) tbl[0].hr[r][r] = 1;
        tbl[0].yre = '{100, 200, -3, 0};
        tbl[0].yim = '{-50, 0, 7, 1};
        tbl[0].zre = '{100, 200, -3, 0};
        tbl[0].zim = '{-50, 0, 7, 1};
        tbl[0].dh  = 'h1234;

        tbl[1] = zero_vec();
        tbl[1].hi[0][0] = 1;
        tbl[1].yre[0] = 10; tbl[1].yim[0] = 20;
        tbl[1].zre[0] = 20; tbl[1].zim[0] = -10;
        tbl[1].dh = 'hBEEF;

        tbl[2] = zero_vec();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tbl[2].hr[r][c] = -128;
                tbl[2].hi[r][c] = -128;
            end
            tbl[2].yre[r] = -32768; tbl[2].yim[r] = -32768;
            tbl[2].zre[r] = 33554432; tbl[2].zim[r] = 0;
        end
        tbl[2].dh = 'hFFFF;

        for (int i = 0; i < 3; i++) begin
            start_op(tbl[i], 0, 0, names[i]);
            feed(tbl[i], 0, 1'b0, names[i]);
        end

        // D_h three cycles ahead of Hq, y strobes during LOAD, gaps between samples.
        v = rand_vec();
        start_op(v, 2, 2, "order");
        feed(v, 3, 1'b0, "order");

        // Reset in the middle of accumulation, then a clean run.
        v = rand_vec();
        start_op(v, 0, 0, "midrst");
        for (int r = 0; r < 2; r++) begin
            bus.y_valid = 1'b1; bus.y_re = 16'(v.yre[r]); bus.y_im = 16'(v.yim[r]);
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b1; bus.ready_Hq = 1'b1; bus.done_Dh = 1'b1;
        tick();
        rst = 1'b1;
        clear_inputs();
        check_all_zero("midrst");
        tick();
        check("midrst_stay_idle", 32'(bus.busy), 32'd0);
        v2 = rand_vec();
        start_op(v2, 0, 0, "after_rst");
        feed(v2, 1, 1'b0, "after_rst");

        // start held high through LOAD, ACC and DONE must not restart the operation.
        v = rand_vec();
        drive_rows(v);
        bus.D_h = 16'(v.dh);
        bus.start = 1'b1;
        tick();
        tick();
        check("busy_start_load", {30'd0, bus.busy, bus.y_ready}, 32'd2);
        bus.ready_Hq = 1'b1; bus.done_Dh = 1'b1;
        tick();
        bus.ready_Hq = 1'b0; bus.done_Dh = 1'b0;
        scramble();
        check("busy_start_acc", 32'(bus.y_ready), 32'd1);
        feed(v, 2, 1'b1, "busy_start");

        // Random operations with random capture order and sample gaps.
        for (int k = 0; k < 20; k++) begin
            v = rand_vec();
            start_op(v, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), $sformatf("rand%0d", k));
            feed(v, 2, 1'b0, $sformatf("rand%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hq_y_match.md
HQ_Y_MATCH -- requirements
Module: hq_y_match

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets the block).
REQ-003 start  input  1  one-cycle pulse that begins a new matched-filter operation.
REQ-004 in_rowHr0..in_rowHr3  input  32 each  real parts of Hq row r; four signed 8-bit elements, [7:0]=col0, [15:8]=col1, [23:16]=col2, [31:24]=col3.
REQ-005 in_rowHi0..in_rowHi3  input  32 each  imaginary parts of Hq row r; same packing as REQ-004.
REQ-006 ready_Hq  input  1  upstream Hq rows valid (level).
REQ-007 D_h  input  16  upstream channel-norm value.
REQ-008 done_Dh  input  1  D_h valid (level or pulse).
REQ-009 y_valid  input  1  received-sample strobe.
REQ-010 y_re, y_im  input  16 each  signed received sample y[r]; samples arrive in row order 0..3.
REQ-011 y_ready  output  1  high when y samples are accepted.
REQ-012 z_re0..z_re3, z_im0..z_im3  output  32 each  signed matched-filter result per column.
REQ-013 Dh_out  output  16  D_h captured for this operation.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; results valid.

Function
REQ-016 FSM states: IDLE, LOAD, ACC, DONE.
REQ-017 IDLE->LOAD on start=1. On the same edge, clear all 8 accumulators, the sample counter, and the h_got/d_got flags.
REQ-018 start in any state other than IDLE is ignored.
REQ-019 In LOAD, ready_Hq=1 latches all 8 row words and sets h_got.
REQ-020 In LOAD, done_Dh=1 latches D_h into Dh_out and sets d_got.
REQ-021 The two captures in LOAD may occur in either order or in the same cycle. Each capture happens once only; later strobes are ignored.
REQ-022 LOAD->ACC on the edge after which h_got and d_got are both set.
REQ-023 y_ready = (state==ACC). y_valid outside ACC is ignored.
REQ-024 In ACC, each accepted sample r (counter value) updates all four columns c in parallel:
- acc_re[c] += Hr[r][c]*y_re + Hi[r][c]*y_im
- acc_im[c] += Hr[r][c]*y_im - Hi[r][c]*y_re
REQ-025 Arithmetic: 8x16 signed products are 24 bits. Accumulators are 32-bit signed and cannot overflow (4 rows fit in 27 bits). Results are exact, with no rounding or saturation.
REQ-026 Counter runs 0..3. Acceptance of the sample at counter=3 moves ACC->DONE. Gaps in y_valid stall without loss.
REQ-027 In DONE: done=1 for exactly one cycle, z_* registers hold the final accumulators, then DONE->IDLE.
REQ-028 z_* and Dh_out hold their values until the next start clears them. Latency from the 4th accepted sample to done=1 is 1 cycle.

Reset
REQ-029 rst=0 at any edge, including mid-operation: state=IDLE; all z_*, Dh_out, accumulators, counter and flags = 0; busy=0, done=0, y_ready=0.
REQ-030 rst takes priority over start and all strobes in the same cycle.

Verification
REQ-031 Identity: Hr rows = 0x00000001<<(8r), Hi=0, D_h=0x1234, y=(100,-50),(200,0),(-3,7),(0,1) -> z_re0..3=100,200,-3,0; z_im0..3=-50,0,7,1; Dh_out=0x1234; done pulses once.
REQ-032 Conjugate sign: Hr=0, Hi row0 col0=1 (others 0), y0=(10,20), other y=0 -> z_re0=20, z_im0=-10, other z=0.
REQ-033 Extremes: all H elements -128 (Hr and Hi), y=(-32768,-32768) x4 -> z_re=+33554432 (0x02000000) for every column, z_im=0, no wrap.
REQ-034 Handshake order: done_Dh three cycles before ready_Hq; y_valid pulsed during LOAD; gaps between y samples -> pre-ACC y ignored, y_ready low until both captured, results match golden model.
REQ-035 Reset mid-ACC after 2 samples, then a fresh start -> all outputs 0 after reset; second run produces correct results with no stale accumulation.
REQ-036 start asserted while busy -> ignored; done pulses exactly once per accepted start.
